// File: rtl/multi_edge_det_pkg.sv
// multi_edge_det_pkg: shared edge-mode encoding and debounce counter sizing
package multi_edge_det_pkg;

  typedef enum logic [1:0] {
    EDGE_OFF  = 2'b00,
    EDGE_RISE = 2'b01,
    EDGE_FALL = 2'b10,
    EDGE_BOTH = 2'b11
  } edge_mode_t;

  // DB_CYCLES of 0 behaves like 1: the new level is taken on its first synchronised cycle
  function automatic int db_eff(input int db);
    return db < 1 ? 1 : db;
  endfunction

  function automatic int cnt_w(input int db);
    return $clog2(db_eff(db) + 1);
  endfunction

endpackage

// File: rtl/multi_edge_det_if.sv
// multi_edge_det_if: pad-side inputs and CSR-side status of the multi-channel edge detector
// MULTI_EDGE_DET_OVERRUN_EN adds the overrun vector
interface multi_edge_det_if #(parameter int NCH = 8);
  logic [NCH-1:0]   async_in;
  logic [2*NCH-1:0] mode;
  logic [NCH-1:0]   clr;
  logic [NCH-1:0]   sync_out;
  logic [NCH-1:0]   edge_pulse;
  logic [NCH-1:0]   pending;
  logic             irq;
`ifdef MULTI_EDGE_DET_OVERRUN_EN
  logic [NCH-1:0]   overrun;
`endif

  modport master (
    output async_in, mode, clr,
`ifdef MULTI_EDGE_DET_OVERRUN_EN
    input  overrun,
`endif
    input  sync_out, edge_pulse, pending, irq
  );

  modport slave (
    input  async_in, mode, clr,
`ifdef MULTI_EDGE_DET_OVERRUN_EN
    output overrun,
`endif
    output sync_out, edge_pulse, pending, irq
  );
endinterface

// File: rtl/multi_edge_det_edge_chan.sv
// edge_chan: one channel - synchroniser, debounce filter, edge qualify, sticky pending
// MULTI_EDGE_DET_OVERRUN_EN adds a sticky overrun flag
module edge_chan
  import multi_edge_det_pkg::*;
#(
  parameter int   SYNC_STAGES = 2,
  parameter int   DB_CYCLES   = 4,
  parameter logic RST_VAL     = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       a,
  input  edge_mode_t mode,
  input  logic       clr,
`ifdef MULTI_EDGE_DET_OVERRUN_EN
  output logic       overrun,
`endif
  output logic       level,
  output logic       edge_pulse,
  output logic       pending
);
  localparam int DB = db_eff(DB_CYCLES);
  localparam int CW = cnt_w(DB_CYCLES);

  logic [SYNC_STAGES-1:0] sync;
  logic                   lp;
  logic [CW-1:0]          cnt;
  logic                   s;
  logic                   rise_en;
  logic                   fall_en;

  always_comb begin
    s          = sync[SYNC_STAGES-1];
    rise_en    = mode == EDGE_RISE || mode == EDGE_BOTH;
    fall_en    = mode == EDGE_FALL || mode == EDGE_BOTH;
    edge_pulse = (rise_en & level & ~lp) | (fall_en & ~level & lp);
  end

  // cnt counts consecutive cycles that s has disagreed with the accepted level
  always_ff @(posedge clk) begin
    if (rst) begin
      sync    <= {SYNC_STAGES{RST_VAL}};
      level   <= RST_VAL;
      lp      <= RST_VAL;
      cnt     <= '0;
      pending <= 1'b0;
    end else begin
      sync    <= {sync[SYNC_STAGES-2:0], a};
      lp      <= level;
      pending <= (pending & ~clr) | edge_pulse;
      if (s == level) begin
        cnt <= '0;
      end else if (cnt == CW'(DB - 1)) begin
        level <= s;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

`ifdef MULTI_EDGE_DET_OVERRUN_EN
  always_ff @(posedge clk) begin
    if (rst) overrun <= 1'b0;
    else     overrun <= (overrun & ~clr) | (edge_pulse & pending & ~clr);
  end
`endif

endmodule

// File: rtl/multi_edge_det.sv
// multi_edge_det: NCH independent debounced edge detectors with sticky flags OR-ed into irq
// MULTI_EDGE_DET_OVERRUN_EN adds per-channel overrun reporting
module multi_edge_det
  import multi_edge_det_pkg::*;
#(
  parameter int   NCH         = 8,
  parameter int   SYNC_STAGES = 2,
  parameter int   DB_CYCLES   = 4,
  parameter logic RST_VAL     = 1'b0
) (
  input logic              clk,
  input logic              rst,
  multi_edge_det_if.slave  bus
);
  logic [NCH-1:0] lvl;
  logic [NCH-1:0] ep;
  logic [NCH-1:0] pd;
`ifdef MULTI_EDGE_DET_OVERRUN_EN
  logic [NCH-1:0] ov;
  assign bus.overrun = ov;
`endif

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    edge_chan #(
      .SYNC_STAGES(SYNC_STAGES),
      .DB_CYCLES  (DB_CYCLES),
      .RST_VAL    (RST_VAL)
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .a         (bus.async_in[i]),
      .mode      (edge_mode_t'(bus.mode[2*i+:2])),
      .clr       (bus.clr[i]),
`ifdef MULTI_EDGE_DET_OVERRUN_EN
      .overrun   (ov[i]),
`endif
      .level     (lvl[i]),
      .edge_pulse(ep[i]),
      .pending   (pd[i])
    );
  end

  assign bus.sync_out   = lvl;
  assign bus.edge_pulse = ep;
  assign bus.pending    = pd;
  assign bus.irq        = |pd;

endmodule

// File: tb/tb_multi_edge_det.sv
// tb_multi_edge_det: directed scenarios plus randomized traffic against a sample-history model
module tb_multi_edge_det;
  localparam int NCH = 4;
  localparam int SS  = 2;
  localparam int DB  = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;

  multi_edge_det_if #(.NCH(NCH)) bus ();

  multi_edge_det #(.NCH(NCH), .SYNC_STAGES(SS), .DB_CYCLES(DB), .RST_VAL(1'b0)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // reference: a channel level flips once the last DB synchronised samples all show the other value
  bit [SS-1:0] m_pipe [NCH];
  bit [31:0]   m_hist [NCH];
  int          m_nv   [NCH];
  bit [NCH-1:0] m_l, m_lp, m_pend, m_ovr;

  function automatic bit [NCH-1:0] exp_pulse();
    bit [NCH-1:0] p;
    bit [1:0] md;
    for (int c = 0; c < NCH; c++) begin
      md = bus.mode[2*c+:2];
      p[c] = (md[0] && m_l[c] && !m_lp[c]) || (md[1] && !m_l[c] && m_lp[c]);
    end
    return p;
  endfunction

  always @(posedge clk) begin
    bit [NCH-1:0] p;
    bit [31:0] mask;
    p = exp_pulse();
    mask = (32'd1 << DB) - 32'd1;
    if (rst) begin
      m_l = '0; m_lp = '0; m_pend = '0; m_ovr = '0;
      for (int c = 0; c < NCH; c++) begin
        m_pipe[c] = '0; m_hist[c] = '0; m_nv[c] = 0;
      end
    end else begin
      m_ovr  = (m_ovr & ~bus.clr) | (p & m_pend & ~bus.clr);
      m_pend = (m_pend & ~bus.clr) | p;
      m_lp   = m_l;
      for (int c = 0; c < NCH; c++) begin
        m_hist[c] = {m_hist[c][30:0], m_pipe[c][SS-1]};
        if (m_nv[c] < 32) m_nv[c]++;
        if (m_nv[c] >= DB && (m_hist[c] & mask) == (m_l[c] ? 32'd0 : mask)) m_l[c] = ~m_l[c];
        m_pipe[c] = {m_pipe[c][SS-2:0], bus.async_in[c]};
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1; bus.async_in = '0; bus.clr = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    bus.async_in = 4'hF; bus.mode = 8'h55; bus.clr = '0; rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      tests++;
      if (bus.sync_out !== 4'h0 || bus.pending !== 4'h0 || bus.irq !== 1'b0) begin
        fails++;
        $display("FAIL reset_hold sync=%h pend=%h irq=%b exp 0/0/0", bus.sync_out, bus.pending, bus.irq);
      end
    end
    rst = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      tests++;
      if (bus.sync_out !== ((k >= 6) ? 4'hF : 4'h0)) begin
        fails++; $display("FAIL reset_sync k=%0d got=%h exp=%h", k, bus.sync_out, (k >= 6) ? 4'hF : 4'h0);
      end
      tests++;
      if (bus.edge_pulse !== ((k == 6) ? 4'hF : 4'h0)) begin
        fails++; $display("FAIL reset_pulse k=%0d got=%h exp=%h", k, bus.edge_pulse, (k == 6) ? 4'hF : 4'h0);
      end
      tests++;
      if (bus.pending !== ((k >= 7) ? 4'hF : 4'h0) || bus.irq !== (k >= 7)) begin
        fails++; $display("FAIL reset_pend k=%0d got=%h irq=%b", k, bus.pending, bus.irq);
      end
    end
  endtask

  task automatic test_glitch();
    int pulses = 0;
    do_reset();
    bus.mode = 8'h55;
    bus.async_in = 4'h1;
    repeat (3) @(negedge clk);
    bus.async_in = 4'h0;
    repeat (12) begin
      @(negedge clk);
      tests++;
      if (bus.sync_out !== 4'h0 || bus.edge_pulse !== 4'h0 || bus.pending !== 4'h0) begin
        fails++;
        $display("FAIL glitch_pass sync=%h pulse=%h pend=%h exp 0", bus.sync_out, bus.edge_pulse, bus.pending);
      end
    end
    bus.async_in = 4'h1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (bus.edge_pulse[0]) pulses++;
      tests++;
      if (bus.sync_out[0] !== (k >= 6) || bus.edge_pulse[0] !== (k == 6)) begin
        fails++;
        $display("FAIL glitch_accept k=%0d sync=%b pulse=%b", k, bus.sync_out[0], bus.edge_pulse[0]);
      end
    end
    tests++;
    if (pulses != 1) begin fails++; $display("FAIL glitch_count got=%0d exp=1", pulses); end
  endtask

  task automatic test_modes();
    int cnt [NCH] = '{0, 0, 0, 0};
    bit seen3 = 1'b0;
    do_reset();
    bus.mode = 8'h2D;
    repeat (4) @(negedge clk);
    bus.async_in = 4'hE;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      for (int c = 0; c < NCH; c++) if (bus.edge_pulse[c]) cnt[c]++;
      if (bus.sync_out[3]) seen3 = 1'b1;
      if (bus.edge_pulse[2]) begin
        tests++;
        if (bus.sync_out[2] !== 1'b0) begin fails++; $display("FAIL mode_fall_dir sync2=%b exp=0", bus.sync_out[2]); end
      end
      if (k == 9) bus.async_in = 4'h0;
    end
    tests++;
    if (cnt[1] != 2 || cnt[2] != 1 || cnt[3] != 0 || cnt[0] != 0) begin
      fails++;
      $display("FAIL mode_counts got=%0d/%0d/%0d/%0d exp=0/2/1/0", cnt[0], cnt[1], cnt[2], cnt[3]);
    end
    tests++;
    if (!seen3 || bus.sync_out[3] !== 1'b0) begin
      fails++; $display("FAIL mode_off_level seen_high=%b final=%b exp 1/0", seen3, bus.sync_out[3]);
    end
  endtask

  task automatic test_clear();
    bit ok = 1'b0;
    do_reset();
    bus.mode = 8'h03;
    bus.async_in = 4'h1;
    for (int k = 0; k < 20 && !ok; k++) begin @(negedge clk); ok = bus.pending[0]; end
    tests++;
    if (!ok) begin fails++; $display("FAIL clr_setup pend=%b exp=1", bus.pending[0]); end
    bus.clr = 4'h1;
    @(negedge clk);
    bus.clr = 4'h0;
    tests++;
    if (bus.pending[0] !== 1'b0 || bus.irq !== 1'b0) begin
      fails++; $display("FAIL clr_clear pend=%b irq=%b exp 0/0", bus.pending[0], bus.irq);
    end
    bus.async_in = 4'h0;
    ok = 1'b0;
    for (int k = 0; k < 20 && !ok; k++) begin @(negedge clk); ok = bus.edge_pulse[0]; end
    tests++;
    if (!ok) begin fails++; $display("FAIL clr_fall_timeout pulse=%b exp=1", bus.edge_pulse[0]); end
    bus.clr = 4'h1;
    @(negedge clk);
    bus.clr = 4'h0;
    tests++;
    if (bus.pending[0] !== 1'b1 || bus.irq !== 1'b1) begin
      fails++; $display("FAIL clr_set_wins pend=%b irq=%b exp 1/1", bus.pending[0], bus.irq);
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    bus.mode = 8'h55;
    bus.async_in = 4'h1;
    repeat (4) @(negedge clk);
    rst = 1'b1; bus.async_in = 4'h0;
    @(negedge clk);
    rst = 1'b0;
    repeat (12) begin
      @(negedge clk);
      tests++;
      if (bus.edge_pulse !== 4'h0 || bus.sync_out !== 4'h0 || bus.pending !== 4'h0) begin
        fails++;
        $display("FAIL midrst sync=%h pulse=%h pend=%h exp 0", bus.sync_out, bus.edge_pulse, bus.pending);
      end
    end
  endtask

`ifdef MULTI_EDGE_DET_OVERRUN_EN
  task automatic test_overrun();
    do_reset();
    bus.mode = 8'h55;
    bus.async_in = 4'h1;
    repeat (10) @(negedge clk);
    tests++;
    if (bus.pending[0] !== 1'b1 || bus.overrun[0] !== 1'b0) begin
      fails++; $display("FAIL ovr_first pend=%b ovr=%b exp 1/0", bus.pending[0], bus.overrun[0]);
    end
    bus.async_in = 4'h0;
    repeat (10) @(negedge clk);
    bus.async_in = 4'h1;
    repeat (10) @(negedge clk);
    tests++;
    if (bus.overrun[0] !== 1'b1) begin fails++; $display("FAIL ovr_set got=%b exp=1", bus.overrun[0]); end
    bus.clr = 4'h1;
    @(negedge clk);
    bus.clr = 4'h0;
    tests++;
    if (bus.pending[0] !== 1'b0 || bus.overrun[0] !== 1'b0) begin
      fails++; $display("FAIL ovr_clr pend=%b ovr=%b exp 0/0", bus.pending[0], bus.overrun[0]);
    end
  endtask
`endif

  task automatic test_random();
    do_reset();
    bus.mode = 8'hFF;
    for (int k = 0; k < 800; k++) begin
      @(negedge clk);
      tests++;
      if (bus.sync_out !== m_l) begin fails++; $display("FAIL rnd_sync k=%0d got=%h exp=%h", k, bus.sync_out, m_l); end
      tests++;
      if (bus.edge_pulse !== exp_pulse()) begin
        fails++; $display("FAIL rnd_pulse k=%0d got=%h exp=%h", k, bus.edge_pulse, exp_pulse());
      end
      tests++;
      if (bus.pending !== m_pend || bus.irq !== |m_pend) begin
        fails++; $display("FAIL rnd_pend k=%0d got=%h irq=%b exp=%h", k, bus.pending, bus.irq, m_pend);
      end
`ifdef MULTI_EDGE_DET_OVERRUN_EN
      tests++;
      if (bus.overrun !== m_ovr) begin fails++; $display("FAIL rnd_ovr k=%0d got=%h exp=%h", k, bus.overrun, m_ovr); end
`endif
      rst = ($urandom_range(0, 299) == 0);
      for (int c = 0; c < NCH; c++) if ($urandom_range(0, 5) == 0) bus.async_in[c] = ~bus.async_in[c];
      if ($urandom_range(0, 39) == 0) bus.mode = 8'($urandom);
      bus.clr = 4'($urandom) & 4'($urandom) & 4'($urandom);
    end
    rst = 1'b0;
    bus.clr = '0;
  endtask

  initial begin
    bus.async_in = '0; bus.mode = '0; bus.clr = '0;
    test_reset();
    test_glitch();
    test_modes();
    test_clear();
    test_mid_reset();
`ifdef MULTI_EDGE_DET_OVERRUN_EN
    test_overrun();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/multi_edge_det.md
Name: multi_edge_det

Overview:
Multi-channel successor to the single-bit edge detector. Each channel has:
- a parametrised-depth synchroniser for an asynchronous input;
- a debounce/glitch filter;
- per-channel runtime edge mode (off/rise/fall/both).

Edges produce a one-cycle pulse and a sticky pending flag with write-1-to-clear. Pending flags are OR-reduced into one interrupt line. The block sits between pad/GPIO-level inputs and the control/CSR logic.

Parameters:
NCH, 8, number of independent channels (>=1)
SYNC_STAGES, 2, synchroniser flops per channel (>=2)
DB_CYCLES, 4, consecutive cycles a new synchronised level must persist before acceptance (0 or 1 = no filtering)
RST_VAL, 1'b0, reset value of every synchroniser flop and filtered level

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
async_in  input  NCH  asynchronous raw inputs
mode  input  2*NCH  per-channel edge mode, bits [2i+1:2i] for channel i: 00 off, 01 rise, 10 fall, 11 both
clr  input  NCH  write-1-to-clear for pending
sync_out  output  NCH  synchronised, filtered level
edge_pulse  output  NCH  one-cycle pulse on a qualifying edge of sync_out
pending  output  NCH  sticky edge flag
irq  output  1  OR of pending

Behaviour:
- Reset (synchronous, active-high, one clk edge with rst=1):
  - sync flops, filtered level and its one-cycle-delayed copy <= RST_VAL;
  - debounce counter <= 0; pending <= 0.
  - Consequently sync_out=RST_VAL, edge_pulse=0, irq=0. No spurious edge is produced on reset exit.
- Synchroniser: async_in feeds a SYNC_STAGES flop chain; s = last stage.
- Filter (per channel), with level L and counter cnt of width $clog2(max(DB_CYCLES,1)+1):
  - s==L: cnt<=0.
  - s!=L and cnt==max(DB_CYCLES,1)-1: L<=s, cnt<=0.
  - Otherwise: cnt<=cnt+1.
  - sync_out = L.
  - A steady input transition appears on sync_out SYNC_STAGES+max(DB_CYCLES,1) edges after first being sampled.
  - A glitch present in s for fewer than DB_CYCLES consecutive cycles never changes L.
- Edge: Lp = L delayed one cycle.
  - edge_pulse[i] = (rise enabled & L & ~Lp) | (fall enabled & ~L & Lp), combinational from registers.
  - The pulse is high exactly in the first cycle sync_out shows the new value.
  - mode is applied combinationally, so a change takes effect the same cycle.
  - Mode 00 still synchronises and filters; only edge_pulse and pending are suppressed.
- Pending: pending <= (pending & ~clr) | edge_pulse.
  - Simultaneous clr and edge_pulse: set wins.
  - Visible the cycle after edge_pulse.
  - irq = |pending, combinational.
- Reset mid-operation: a partially counted debounce is discarded. An input held at RST_VAL through and after reset yields no edge.

Optional Feature:
MULTI_EDGE_DET_OVERRUN_EN
- Defined: adds output port overrun (NCH).
  - overrun[i] <= (overrun[i] & ~clr[i]) | (edge_pulse[i] & pending[i] & ~clr[i]).
  - It sets when an edge arrives while pending is already set and not being cleared that cycle.
  - Reset to 0. clr clears pending and overrun together.
- Undefined: port and logic absent; all other behaviour identical.

Decomposition:
- Package multi_edge_det_pkg:
  - edge_mode_t enum (EDGE_OFF=2'b00, EDGE_RISE=2'b01, EDGE_FALL=2'b10, EDGE_BOTH=2'b11);
  - helper constant function for the counter width.
- Sub-module edge_chan: one channel covering synchroniser, filter, Lp, edge, pending and optional overrun.
- Top instantiates NCH copies in a generate loop and forms irq.

Test Plan:
All tests use NCH=4, SYNC_STAGES=2, DB_CYCLES=4, RST_VAL=0.
- Reset: async_in=4'hF, mode all 01, rst=1 for 3 cycles.
  -> sync_out=0, pending=0, irq=0 during reset.
  -> sync_out=4'hF exactly 6 edges after release, with a one-cycle edge_pulse=4'hF.
  -> pending=4'hF the next cycle.
- Glitch filter on ch0 (mode 01):
  -> input high 3 cycles then low: no sync_out, pulse or pending change.
  -> input high 4 or more cycles: sync_out[0] rises at edge 6 after first sample, single edge_pulse[0].
- Modes: ch1=11, ch2=10, ch3=00, each driven 0->1->0 with 10-cycle holds.
  -> ch1 gives 2 pulses, ch2 gives 1 pulse (on fall), ch3 gives 0 pulses.
  -> sync_out[3] still toggles.
- Clear: pending[0]=1, clr[0]=1 for one cycle -> pending[0]=0 and irq=0 next cycle.
  -> clr[0]=1 in the same cycle as edge_pulse[0] -> pending[0] remains 1.
- Reset mid-debounce: ch0 high for 2 synchronised cycles, then rst pulse, input back to 0.
  -> no edge_pulse and cnt=0 after release.
- MULTI_EDGE_DET_OVERRUN_EN: two rising edges on ch0 without clr -> overrun[0]=1.
  -> clr[0] clears pending[0] and overrun[0] in the same cycle.
  -> Macro undefined: the first four tests produce the same results.
